// File: rtl/uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// uart_tx_buffered
//
// Buffered UART transmitter. Bytes offered on data/valid are queued in a
// circular FIFO and serialised on tx as frames of the form
//   start(0) | DATA_BITS data bits, LSB first | optional parity | stop bit(s)
// Every bit period lasts DIV = CLK_FREQ / BAUD clock cycles. When more bytes
// are waiting at the end of a frame, the next start bit follows the last stop
// bit with no idle gap.
//
// Parameters
//   CLK_FREQ   clock frequency in Hz
//   BAUD       line rate; DIV = CLK_FREQ / BAUD must be >= 2
//   DATA_BITS  data bits per frame, 5..9
//   PARITY     0 none, 1 odd, 2 even
//   STOP_BITS  1 or 2
//   FIFO_DEPTH queue depth, power of two >= 2
//
// Ports
//   clock     in   sole clock, rising edge
//   reset     in   asynchronous active-high reset
//   data      in   byte to enqueue, taken when valid && ready
//   valid     in   producer offers data this cycle
//   ready     out  FIFO can accept this cycle (not full, not in reset)
//   overflow  out  one-cycle pulse: valid was high while ready was low
//   count     out  entries waiting in the FIFO (frame in flight excluded)
//   busy      out  transmitter is not idle
//   tx        out  registered serial line, idles high
// ----------------------------------------------------------------------------
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        data,
  input  logic                        valid,
  output logic                        ready,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BCW = 4;

  // Reject parameter sets the datapath below cannot represent.
  if (DIV < 2) begin : gDivCheck
    $error("uart_tx_buffered: CLK_FREQ / BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : gBitsCheck
    $error("uart_tx_buffered: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : gParityCheck
    $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : gStopCheck
    $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gDepthCheck
    $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  // Frame sequencer state.
  state_e               state_q, state_d;
  logic [DCW-1:0]       divCnt_q, divCnt_d;
  logic [BCW-1:0]       bitCnt_q, bitCnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;

  // FIFO state.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, rdPtr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q;

  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 periodEnd;
  logic [DATA_BITS-1:0] headData;

  // A pop never frees space for a write in the same cycle: ready only looks
  // at the current occupancy, so a full FIFO refuses even while draining.
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign ready    = !full && !reset;
  assign push     = valid && ready;
  assign headData = mem_q[rdPtr_q];
  assign count_d  = count_q + CW'(push) - CW'(pop);

  // Storage array. It carries no reset: an empty FIFO never exposes its
  // contents, and every slot is written before it can be popped.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wrPtr_q] <= data;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two, so
  // ordering survives wrap-around without extra compare logic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      count_q    <= count_d;
      overflow_q <= valid && !ready;
    end
  end

  // Sequencer next-state logic. The baud counter runs in every non-idle
  // state and wraps at DIV-1; bitCnt indexes data bits in DATA and stop bits
  // in STOP. A pop (from IDLE or on the last STOP cycle) always overrides
  // the normal transition and restarts the frame at START.
  always_comb begin
    state_d   = state_q;
    divCnt_d  = divCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    pop       = 1'b0;
    periodEnd = (divCnt_q == DCW'(DIV - 1));

    if (state_q != ST_IDLE) begin
      divCnt_d = periodEnd ? '0 : divCnt_q + DCW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
        end
      end
      ST_START: begin
        if (periodEnd) begin
          state_d  = ST_DATA;
          bitCnt_d = '0;
        end
      end
      ST_DATA: begin
        if (periodEnd) begin
          if (bitCnt_q == BCW'(DATA_BITS - 1)) begin
            bitCnt_d = '0;
            state_d  = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bitCnt_d = bitCnt_q + BCW'(1);
            shift_d  = shift_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (periodEnd) begin
          state_d  = ST_STOP;
          bitCnt_d = '0;
        end
      end
      ST_STOP: begin
        if (periodEnd) begin
          if (bitCnt_q == BCW'(STOP_BITS - 1)) begin
            if (count_q != '0) begin
              pop = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bitCnt_d = bitCnt_q + BCW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Parity is fixed when the byte is loaded: XOR of the data gives even
    // parity, inverting it gives odd parity.
    if (pop) begin
      state_d  = ST_START;
      divCnt_d = '0;
      bitCnt_d = '0;
      shift_d  = headData;
      parity_d = (^headData) ^ (PARITY == 1);
    end

    // tx is registered, so it is derived from the state being entered.
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // Sequencer registers; reset abandons any frame in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      divCnt_q <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      divCnt_q <= divCnt_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign count    = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_buffered
//
// Five transmitters with different frame formats share one stimulus stream.
// A queue-based model predicts, per instance, the FIFO contents and the
// per-cycle line level of each frame; every outputs is compared against it
// on each falling clock edge. Directed phases add hand-computed waveforms.
//   u0: 8N1 depth 16   u1: 8E1   u2: 8O1   u3: 8N1 depth 4   u4: 7N2
// ----------------------------------------------------------------------------
module tb_uart_tx_buffered;

  localparam int NI       = 5;
  localparam int CLK_FREQ = 12000000;
  localparam int BAUD     = 3000000;
  localparam int DIV      = CLK_FREQ / BAUD;

  int cfgBits  [NI] = '{8, 8, 8, 8, 7};
  int cfgPar   [NI] = '{0, 2, 1, 0, 0};
  int cfgStop  [NI] = '{1, 1, 1, 1, 2};
  int cfgDepth [NI] = '{16, 16, 16, 4, 16};

  logic       clock  = 1'b0;
  logic       reset  = 1'b1;
  logic       valid  = 1'b0;
  logic [7:0] dataIn = 8'h00;

  logic       txW    [NI];
  logic       busyW  [NI];
  logic       ovfW   [NI];
  logic       readyW [NI];
  logic [4:0] cnt0, cnt1, cnt2, cnt4;
  logic [2:0] cnt3;

  // Model state: waiting bytes and remaining line levels of the frame in flight.
  logic [8:0] fifoQ [NI][$];
  bit         lineQ [NI][$];
  int         expTx    [NI] = '{1, 1, 1, 1, 1};
  int         expBusy  [NI] = '{0, 0, 0, 0, 0};
  int         expOvf   [NI] = '{0, 0, 0, 0, 0};
  int         expCount [NI] = '{0, 0, 0, 0, 0};
  bit         mCanTake;
  logic [8:0] mByte;

  int total = 0;
  int bad   = 0;

  bit capTx   [NI][64];
  bit capBusy [NI][64];

  always #5 clock = ~clock;

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
    .clock(clock), .reset(reset), .data(dataIn), .valid(valid), .ready(readyW[0]),
    .overflow(ovfW[0]), .count(cnt0), .busy(busyW[0]), .tx(txW[0]));

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
    .clock(clock), .reset(reset), .data(dataIn), .valid(valid), .ready(readyW[1]),
    .overflow(ovfW[1]), .count(cnt1), .busy(busyW[1]), .tx(txW[1]));

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
    .clock(clock), .reset(reset), .data(dataIn), .valid(valid), .ready(readyW[2]),
    .overflow(ovfW[2]), .count(cnt2), .busy(busyW[2]), .tx(txW[2]));

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clock(clock), .reset(reset), .data(dataIn), .valid(valid), .ready(readyW[3]),
    .overflow(ovfW[3]), .count(cnt3), .busy(busyW[3]), .tx(txW[3]));

  uart_tx_buffered #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(0),
                     .STOP_BITS(2), .FIFO_DEPTH(16)) u4 (
    .clock(clock), .reset(reset), .data(dataIn[6:0]), .valid(valid), .ready(readyW[4]),
    .overflow(ovfW[4]), .count(cnt4), .busy(busyW[4]), .tx(txW[4]));

  function automatic int getCount(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      2:       return int'(cnt2);
      3:       return int'(cnt3);
      default: return int'(cnt4);
    endcase
  endfunction

  task automatic checkOutput(input string name, input int inst, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s u%0d at %0t: got %0d, expected %0d", name, inst, $time, act, exp);
    end
  endtask

  // Expand one byte into its per-cycle line levels.
  task automatic loadFrame(input int i, input logic [8:0] b);
    bit bits[$];
    int ones;
    ones = 0;
    bits.push_back(1'b0);
    for (int k = 0; k < cfgBits[i]; k++) begin
      bits.push_back(b[k]);
      ones += int'(b[k]);
    end
    if (cfgPar[i] == 1) bits.push_back(ones % 2 == 0);
    else if (cfgPar[i] == 2) bits.push_back(ones % 2 == 1);
    for (int k = 0; k < cfgStop[i]; k++) bits.push_back(1'b1);
    foreach (bits[k]) repeat (DIV) lineQ[i].push_back(bits[k]);
  endtask

  // Model update at each rising edge (or reset assertion): a new frame starts
  // whenever the previous one has run out and a byte is waiting; a write is
  // accepted only if the queue had room before this edge.
  initial forever begin
    @(posedge clock or posedge reset);
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        fifoQ[i].delete();
        lineQ[i].delete();
        expTx[i]    = 1;
        expBusy[i]  = 0;
        expOvf[i]   = 0;
        expCount[i] = 0;
      end else begin
        mCanTake = fifoQ[i].size() < cfgDepth[i];
        if (lineQ[i].size() == 0 && fifoQ[i].size() > 0) begin
          mByte = fifoQ[i].pop_front();
          loadFrame(i, mByte);
        end
        if (valid && mCanTake) fifoQ[i].push_back(9'(dataIn) & 9'((1 << cfgBits[i]) - 1));
        expOvf[i] = (valid && !mCanTake) ? 1 : 0;
        if (lineQ[i].size() > 0) begin
          expTx[i]   = int'(lineQ[i].pop_front());
          expBusy[i] = 1;
        end else begin
          expTx[i]   = 1;
          expBusy[i] = 0;
        end
        expCount[i] = fifoQ[i].size();
      end
    end
  end

  // Cycle-by-cycle comparison of every instance against the model.
  initial forever begin
    @(negedge clock);
    for (int i = 0; i < NI; i++) begin
      checkOutput("tx", i, int'(txW[i]), expTx[i]);
      checkOutput("busy", i, int'(busyW[i]), expBusy[i]);
      checkOutput("overflow", i, int'(ovfW[i]), expOvf[i]);
      checkOutput("count", i, getCount(i), expCount[i]);
      checkOutput("ready", i, int'(readyW[i]),
                  (!reset && fifoQ[i].size() < cfgDepth[i]) ? 1 : 0);
    end
  end

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    valid  = v;
    dataIn = d;
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic doReset();
    @(posedge clock);
    #1 reset = 1'b1;
    applyStimulus(1'b0, 8'h00);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Offer one byte for one cycle, then record n cycles starting one edge
  // after acceptance.
  task automatic sendAndCapture(input logic [7:0] d, input int n);
    applyStimulus(1'b1, d);
    @(posedge clock);
    #1 applyStimulus(1'b0, 8'h00);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < NI; i++) begin
        capTx[i][k]   = txW[i];
        capBusy[i][k] = busyW[i];
      end
    end
  endtask

  function automatic int busySum(input int i, input int n);
    int s;
    s = 0;
    for (int k = 0; k < n; k++) s += int'(capBusy[i][k]);
    return s;
  endfunction

  initial begin
    int pat30 [10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    int pat55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1};
    int ovfPulses, busyCycles, lowCycles, thr;

    // Reset release values.
    doReset();
    @(posedge clock);
    #1;
    checkOutput("rst.tx", 0, int'(txW[0]), 1);
    checkOutput("rst.ready", 0, int'(readyW[0]), 1);
    checkOutput("rst.busy", 0, int'(busyW[0]), 0);
    checkOutput("rst.count", 0, getCount(0), 0);
    checkOutput("rst.overflow", 0, int'(ovfW[0]), 0);

    // 8N1 frame of 0x30.
    sendAndCapture(8'h30, 48);
    for (int k = 0; k < 40; k++) checkOutput("frame30.tx", 0, int'(capTx[0][k]), pat30[k / DIV]);
    checkOutput("frame30.busycycles", 0, busySum(0, 48), 40);
    checkOutput("frame30.idle", 0, int'(capTx[0][40]), 1);

    // Parity bit of 0x31: even mode 1, odd mode 0; 44-cycle frames.
    doReset();
    sendAndCapture(8'h31, 48);
    for (int k = 36; k < 40; k++) begin
      checkOutput("parity.even", 1, int'(capTx[1][k]), 1);
      checkOutput("parity.odd", 2, int'(capTx[2][k]), 0);
    end
    checkOutput("parity.even.busycycles", 1, busySum(1, 48), 44);
    checkOutput("parity.odd.busycycles", 2, busySum(2, 48), 44);

    // 7N2 frame of 0x55.
    doReset();
    sendAndCapture(8'h55, 48);
    for (int k = 0; k < 40; k++) checkOutput("frame55.tx", 4, int'(capTx[4][k]), pat55[k / DIV]);
    checkOutput("frame55.busycycles", 4, busySum(4, 48), 40);

    // Depth-4 FIFO flooded with 0x41..0x46 on consecutive cycles.
    doReset();
    applyStimulus(1'b1, 8'h41);
    ovfPulses  = 0;
    busyCycles = 0;
    for (int k = 0; k < 226; k++) begin
      @(posedge clock);
      #1;
      ovfPulses  += int'(ovfW[3]);
      busyCycles += int'(busyW[3]);
      if (k == 5) checkOutput("flood.count", 3, getCount(3), 4);
      if (k < 5) applyStimulus(1'b1, dataIn + 8'h01);
      else applyStimulus(1'b0, 8'h00);
    end
    checkOutput("flood.overflowpulses", 3, ovfPulses, 1);
    checkOutput("flood.busycycles", 3, busyCycles, 200);

    // Reset in the middle of a data bit with three bytes still queued.
    doReset();
    applyStimulus(1'b1, 8'h00);
    repeat (4) @(posedge clock);
    #1 applyStimulus(1'b0, 8'h00);
    repeat (6) @(posedge clock);
    #1;
    checkOutput("midreset.pre.tx", 0, int'(txW[0]), 0);
    checkOutput("midreset.pre.count", 0, getCount(0), 3);
    reset = 1'b1;
    #1;
    checkOutput("midreset.tx", 0, int'(txW[0]), 1);
    checkOutput("midreset.count", 0, getCount(0), 0);
    checkOutput("midreset.busy", 0, int'(busyW[0]), 0);
    checkOutput("midreset.ready", 0, int'(readyW[0]), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    lowCycles  = 0;
    busyCycles = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clock);
      #1;
      lowCycles  += (txW[0] == 1'b0) ? 1 : 0;
      busyCycles += int'(busyW[0]);
    end
    checkOutput("midreset.after.txlow", 0, lowCycles, 0);
    checkOutput("midreset.after.busy", 0, busyCycles, 0);

    // Random traffic in bursts of varying density, with one reset inside.
    doReset();
    thr = 12;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clock);
      #1;
      if (c % 400 == 0) thr = $urandom_range(0, 16);
      if (c == 2000) reset = 1'b1;
      if (c == 2003) reset = 1'b0;
      applyStimulus($urandom_range(0, 15) < thr, 8'($urandom));
    end
    applyStimulus(1'b0, 8'h00);
    repeat (900) @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) checkOutput("drain.busy", i, int'(busyW[i]), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLK_FREQ, default 12000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate; DIV = CLK_FREQ/BAUD (integer floor), DIV >= 2.
REQ-003 Parameter DATA_BITS, default 8, legal 5..9.
REQ-004 Parameter PARITY, default 0, encoding: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, power of two >= 2; CW = $clog2(FIFO_DEPTH)+1.
REQ-007 clock  input  1  sole clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-009 data  input  DATA_BITS  byte to enqueue, sampled when valid && ready.
REQ-010 valid  input  1  producer offers data this cycle.
REQ-011 ready  output  1  FIFO can accept this cycle (combinational: not full and not reset).
REQ-012 overflow  output  1  registered one-cycle pulse: valid was high while ready was low on the previous cycle.
REQ-013 count  output  CW  number of entries in the FIFO, excluding the frame being shifted.
REQ-014 busy  output  1  high whenever the state machine is not IDLE.
REQ-015 tx  output  1  registered serial line, idle high.

Function
REQ-016 Write: on an edge with valid && ready, data SHALL be stored at the FIFO tail; writes with ready low SHALL be dropped, with the FIFO unchanged.
REQ-017 The FIFO SHALL be circular; pointer wrap at FIFO_DEPTH SHALL NOT corrupt ordering; output order SHALL equal accept order.
REQ-018 A simultaneous write and pop SHALL leave count unchanged; a pop SHALL never occur when count == 0; a write SHALL never be accepted when count == FIFO_DEPTH, even if a pop occurs that cycle.
REQ-019 States: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: tx = 1; if count > 0, pop the head into the shift register, then enter START.
REQ-021 Each of START, DATA-bit, PARITY and STOP-bit periods SHALL last exactly DIV cycles, timed by an internal counter that restarts at 0 on entry to START.
REQ-022 START drives tx = 0; DATA drives data bits LSB first, DATA_BITS periods; PARITY is skipped when PARITY = 0.
REQ-023 Parity bit value: odd mode makes the total count of ones over data+parity odd; even mode makes it even.
REQ-024 STOP drives tx = 1 for STOP_BITS periods.
REQ-025 On the last cycle of STOP: if count > 0, pop and enter START directly with zero idle cycles between frames; otherwise enter IDLE.
REQ-026 Latency: a byte accepted at edge N into an empty FIFO while IDLE SHALL be popped at edge N+1; tx SHALL be 0 from edge N+1; the frame SHALL last DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles.
REQ-027 Writes during an active frame SHALL NOT disturb the frame in flight.

Reset
REQ-028 While reset is high, and immediately on assertion: tx = 1, state = IDLE, FIFO empty, count = 0, busy = 0, overflow = 0, ready = 0; the baud counter and shift register are cleared.
REQ-029 A frame interrupted by reset SHALL NOT resume; after release ready = 1 and the block idles until a new write.

Verification (CLK_FREQ = 12000000, BAUD = 3000000, so DIV = 4; other parameters default unless stated)
REQ-030 Reset release -> tx=1, ready=1, busy=0, count=0, overflow=0.
REQ-031 Single write of 0x30 (8N1) -> tx low from the edge after accept for 4 cycles, then data bits 0,0,0,0,1,1,0,0 at 4 cycles each, then high for 4 cycles; busy high for 40 cycles.
REQ-032 PARITY=2, data 0x31 -> parity bit 1; PARITY=1, data 0x31 -> parity bit 0; frame is 44 cycles.
REQ-033 FIFO_DEPTH=4, valid held high with 0x41..0x46 on consecutive cycles -> 0x41..0x45 accepted, 0x46 rejected, one overflow pulse; frames for 0x41..0x45 emitted back-to-back, tx never high longer than the stop period between them.
REQ-034 Reset asserted mid-DATA with 3 bytes queued -> tx=1 and count=0 asynchronously; no further frames after release.
REQ-035 DATA_BITS=7, STOP_BITS=2, data 0x55 -> bits 1,0,1,0,1,0,1 then 8 cycles high; frame is 40 cycles.
